// File: rtl/game_tick_pkg.sv
// game_tick_pkg: shared defaults, index/period typedefs and the write-response
// encoding for the multi-channel game-tick generator.
package game_tick_pkg;

  localparam int unsigned NUM_CH_C         = 4;
  localparam int unsigned CNT_W_C          = 24;
  localparam int unsigned FRAME_W_C        = 16;
  localparam int unsigned DEFAULT_PERIOD_C = 1666667;  // 60 Hz at 100 MHz

  // Channel-select width: at least one bit, even for a single channel.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [ch_idx_w(NUM_CH_C)-1:0] ch_idx_t;
  typedef logic [CNT_W_C-1:0]            period_t;

  // Registered outcome of one configuration write.
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_ACK  = 2'd1,
    WR_ERR  = 2'd2
  } wr_rsp_e;

endpackage

// File: rtl/game_tick_gen_channel.sv
// tick_channel: one period register, one down-counter and the registered
// scene-enable pulse. A new period lands at the next reload while running,
// and immediately in the counter while the channel is disabled.
module tick_channel #(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned DEFAULT_PERIOD = 1666667
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_pause,
  input  logic             i_step,     // already qualified by pause
  input  logic             i_we,       // validated write for this channel
  input  logic [CNT_W-1:0] i_period,
  output logic             o_scen
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_PER = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_CNT = RST_PER - ONE;

  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_cnt;
  logic             r_scen;

  // Period register, counter and pulse flop; pause beats terminal count,
  // and a reload always uses the period held before this cycle's write.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let r_cnt see the new r_per.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per  <= RST_PER;
      r_cnt  <= RST_CNT;
      r_scen <= 1'b0;
    end else begin
      if (i_we) begin
        r_per <= i_period;
      end
      if (!i_en) begin
        r_cnt  <= (i_we ? i_period : r_per) - ONE;
        r_scen <= 1'b0;
      end else if (i_step) begin
        r_cnt  <= r_per - ONE;
        r_scen <= 1'b1;
      end else if (i_pause) begin
        r_scen <= 1'b0;
      end else if (r_cnt == '0) begin
        r_cnt  <= r_per - ONE;
        r_scen <= 1'b1;
      end else begin
        r_cnt  <= r_cnt - ONE;
        r_scen <= 1'b0;
      end
    end
  end

  assign o_scen = r_scen;

endmodule

// File: rtl/game_tick_gen.sv
// game_tick_gen: NUM_CH independently programmable scene-enable generators,
// runtime period writes with ack/err, global pause and a frame counter
// driven by channel 0. Optional single-step while paused: GAME_TICK_STEP_EN.
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int unsigned NUM_CH         = NUM_CH_C,
  parameter int unsigned CNT_W          = CNT_W_C,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_C,
  parameter int unsigned FRAME_W        = FRAME_W_C
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             i_ch_en,
  input  logic                          i_pause,
`ifdef GAME_TICK_STEP_EN
  input  logic                          i_step,
`endif
  input  logic                          i_cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]              i_cfg_period,
  output logic                          o_cfg_ack,
  output logic                          o_cfg_err,
  output logic [NUM_CH-1:0]             o_scen,
  output logic [FRAME_W-1:0]            o_frame_cnt
);

  logic               w_cfg_ok;
  logic               w_step;
  logic [NUM_CH-1:0]  w_ch_we;
  wr_rsp_e            r_rsp;
  logic [FRAME_W-1:0] r_frame;

  // A write is legal only for an existing channel and a non-zero period.
  assign w_cfg_ok = (i_cfg_period != '0) && (32'(i_cfg_ch) < NUM_CH);

`ifdef GAME_TICK_STEP_EN
  assign w_step = i_pause & i_step;
`else
  assign w_step = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch_we[g] = i_cfg_we && w_cfg_ok && (32'(i_cfg_ch) == g);

    tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (i_ch_en[g]),
      .i_pause  (i_pause),
      .i_step   (w_step),
      .i_we     (w_ch_we[g]),
      .i_period (i_cfg_period),
      .o_scen   (o_scen[g])
    );
  end

  // One-cycle registered response to every write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= WR_NONE;
    end else if (!i_cfg_we) begin
      r_rsp <= WR_NONE;
    end else begin
      r_rsp <= w_cfg_ok ? WR_ACK : WR_ERR;
    end
  end

  // Frame counter advances once per channel-0 pulse and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else begin
      r_frame <= r_frame + FRAME_W'(o_scen[0]);
    end
  end

  assign o_cfg_ack   = (r_rsp == WR_ACK);
  assign o_cfg_err   = (r_rsp == WR_ERR);
  assign o_frame_cnt = r_frame;

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: scoreboard bench. Stimulus pushes the expected output
// events (edge number, scen, ack, err, frame_cnt) into a queue; a monitor pops
// and compares whenever the DUT drives any pulse. Two instances: a 4-channel
// one with short default period and 4-bit frame counter, and a 3-channel one
// for out-of-range writes.
module tb_game_tick_gen;

  typedef struct {
    int          cyc;
    logic [3:0]  scen;
    logic        ack;
    logic        err;
    logic [15:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   t0 = 0;
  bit   done = 1'b0;

  exp_t q[$];
  exp_t q3[$];
  exp_t m_e;
  exp_t m_e3;

  // main DUT
  logic [3:0]  ch_en;
  logic        pause;
  logic        step;
  logic        we;
  logic [1:0]  ch;
  logic [23:0] per;
  logic        ack;
  logic        err;
  logic [3:0]  scen;
  logic [3:0]  frame;

  // 3-channel DUT
  logic [2:0]  en3;
  logic        we3;
  logic [1:0]  ch3;
  logic [23:0] per3;
  logic        ack3;
  logic        err3;
  logic [2:0]  scen3;
  logic [15:0] frame3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_tick_gen #(
    .NUM_CH(4), .CNT_W(24), .DEFAULT_PERIOD(8), .FRAME_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_ch_en(ch_en), .i_pause(pause),
`ifdef GAME_TICK_STEP_EN
    .i_step(step),
`endif
    .i_cfg_we(we), .i_cfg_ch(ch), .i_cfg_period(per),
    .o_cfg_ack(ack), .o_cfg_err(err), .o_scen(scen), .o_frame_cnt(frame)
  );

  game_tick_gen #(
    .NUM_CH(3), .CNT_W(24), .DEFAULT_PERIOD(8), .FRAME_W(16)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .i_ch_en(en3), .i_pause(1'b0),
`ifdef GAME_TICK_STEP_EN
    .i_step(1'b0),
`endif
    .i_cfg_we(we3), .i_cfg_ch(ch3), .i_cfg_period(per3),
    .o_cfg_ack(ack3), .o_cfg_err(err3), .o_scen(scen3), .o_frame_cnt(frame3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] s, input logic a, input logic e,
                      input logic [15:0] f);
    exp_t x;
    x.cyc = c; x.scen = s; x.ack = a; x.err = e; x.frame = f;
    q.push_back(x);
  endtask

  task automatic push3(input int c, input logic [3:0] s, input logic a, input logic e,
                       input logic [15:0] f);
    exp_t x;
    x.cyc = c; x.scen = s; x.ack = a; x.err = e; x.frame = f;
    q3.push_back(x);
  endtask

  // Wait for the falling edge that follows edge number c.
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Assert reset from a falling edge, check reset outputs, release.
  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = '0; pause = 1'b0; step = 1'b0; we = 1'b0; ch = '0; per = '0;
    en3 = '0; we3 = 1'b0; ch3 = '0; per3 = '0;
    repeat (2) @(negedge clk);
    check("rst_scen",  32'(scen),  0);
    check("rst_frame", 32'(frame), 0);
    check("rst_ackerr", 32'({ack, err}), 0);
    check("rst3_ackerr", 32'({ack3, err3}), 0);
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  // Monitor: every visible pulse must match the head of its queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scen != '0 || ack || err) begin
        if (q.size() == 0) begin
          check("main_unexpected", 32'({scen, ack, err}), 0);
        end else begin
          m_e = q.pop_front();
          check("main_edge",  32'(cyc), 32'(m_e.cyc));
          check("main_scen",  32'(scen), 32'(m_e.scen));
          check("main_ackerr", 32'({ack, err}), 32'({m_e.ack, m_e.err}));
          check("main_frame", 32'(frame), 32'(m_e.frame[3:0]));
        end
      end
      if (scen3 != '0 || ack3 || err3) begin
        if (q3.size() == 0) begin
          check("d3_unexpected", 32'({scen3, ack3, err3}), 0);
        end else begin
          m_e3 = q3.pop_front();
          check("d3_edge",  32'(cyc), 32'(m_e3.cyc));
          check("d3_scen",  32'(scen3), 32'(m_e3.scen));
          check("d3_ackerr", 32'({ack3, err3}), 32'({m_e3.ack, m_e3.err}));
          check("d3_frame", 32'(frame3), 32'(m_e3.frame));
        end
      end
    end
  end

  initial begin
    int np;
    logic [3:0] s;

    // Phase A/B: period 10 on ch0, three pulses, then a 25-cycle pause at cnt=3.
    do_reset();
    push(t0 + 1,  4'b0000, 1'b1, 1'b0, 0);
    push(t0 + 11, 4'b0001, 1'b0, 1'b0, 0);
    push(t0 + 21, 4'b0001, 1'b0, 1'b0, 1);
    push(t0 + 31, 4'b0001, 1'b0, 1'b0, 2);
    push(t0 + 66, 4'b0001, 1'b0, 1'b0, 3);
    push(t0 + 76, 4'b0001, 1'b0, 1'b0, 4);
    we = 1'b1; ch = 2'd0; per = 24'd10;
    at(t0 + 1);
    we = 1'b0; ch_en = 4'b0001;
    at(t0 + 32);
    check("frame_after_3", 32'(frame), 3);
    at(t0 + 37);
    pause = 1'b1;
    at(t0 + 50);
    check("frame_in_pause", 32'(frame), 3);
    at(t0 + 62);
    pause = 1'b0;
    at(t0 + 80);

    // Phase C: write period 5 to ch1 in its terminal-count cycle (old period 8).
    do_reset();
    ch_en = 4'b0010;
    push(t0 + 8,  4'b0010, 1'b0, 1'b0, 0);
    push(t0 + 16, 4'b0010, 1'b1, 1'b0, 0);
    push(t0 + 24, 4'b0010, 1'b0, 1'b0, 0);
    push(t0 + 29, 4'b0010, 1'b0, 1'b0, 0);
    push(t0 + 34, 4'b0010, 1'b0, 1'b0, 0);
    at(t0 + 15);
    we = 1'b1; ch = 2'd1; per = 24'd5;
    at(t0 + 16);
    we = 1'b0;
    at(t0 + 36);

    // Phase D: ch0 period 2 for frame wrap, ch2 period 1 (continuous).
    do_reset();
    push(t0 + 1, 4'b0000, 1'b1, 1'b0, 0);
    push(t0 + 2, 4'b0000, 1'b1, 1'b0, 0);
    np = 0;
    for (int e = t0 + 3; e <= t0 + 35; e++) begin
      s = 4'b0100;
      if (e >= t0 + 4 && ((e - t0 - 4) % 2) == 0) s[0] = 1'b1;
      push(e, s, 1'b0, 1'b0, 16'(np % 16));
      if (s[0]) np++;
    end
    we = 1'b1; ch = 2'd0; per = 24'd2;
    at(t0 + 1);
    ch = 2'd2; per = 24'd1;
    at(t0 + 2);
    we = 1'b0; ch_en = 4'b0101;
    at(t0 + 35);
    check("frame_wrap", 32'(frame), 0);

`ifdef GAME_TICK_STEP_EN
    // Phase E: one-cycle step while paused, then resume.
    do_reset();
    ch_en = 4'b0101; pause = 1'b1;
    push(t0 + 3,  4'b0101, 1'b0, 1'b0, 0);
    push(t0 + 20, 4'b0101, 1'b0, 1'b0, 1);
    at(t0 + 2);
    step = 1'b1;
    at(t0 + 3);
    step = 1'b0;
    at(t0 + 4);
    check("frame_step", 32'(frame), 1);
    at(t0 + 12);
    pause = 1'b0;
    at(t0 + 21);
`endif

    // Phase F: 3-channel instance, illegal channel and zero period.
    do_reset();
    push3(t0 + 1,  4'b0000, 1'b0, 1'b1, 0);
    push3(t0 + 2,  4'b0000, 1'b0, 1'b1, 0);
    push3(t0 + 4,  4'b0000, 1'b1, 1'b0, 0);
    push3(t0 + 10, 4'b0001, 1'b0, 1'b0, 0);
    push3(t0 + 18, 4'b0001, 1'b0, 1'b0, 1);
    we3 = 1'b1; ch3 = 2'd3; per3 = 24'd5;
    at(t0 + 1);
    ch3 = 2'd0; per3 = 24'd0;
    at(t0 + 2);
    we3 = 1'b0; en3 = 3'b001;
    at(t0 + 3);
    we3 = 1'b1; ch3 = 2'd2; per3 = 24'd4;
    at(t0 + 4);
    we3 = 1'b0;
    at(t0 + 20);

    check("main_missing", 32'(q.size()), 0);
    check("d3_missing", 32'(q3.size()), 0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: edge %0d reached without completion", cyc);
      $fatal(1);
    end
  end

endmodule
